explosion_renderer: RTL and testbench

Per-pixel renderer for the tank-game explosion animation, sitting directly downstream of the explosion sprite ROM (3072 x 8, 12-bit address, one-cycle read latency) and upstream of the VGA pixel mux. On a trigger it latches a screen position and plays a 3-frame, 32x32 animation paced by frame ticks. During scanout it converts the current beam position into ROM addresses and emits a registered colour with a valid flag. Transparent texels are suppressed.

---
 rtl/explosion_renderer.sv | 151 +++++++++++++++
 tb/tb_explosion_renderer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/explosion_renderer.sv
// Explosion animation renderer: a trigger/frame-tick FSM plus a 2-stage pixel pipeline around an external sprite ROM.
// Optional EXPLOSION_SCALE2X_EN doubles the on-screen window so that each texel covers a 2x2 pixel block.
module explosion_renderer #(
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter int          NUM_FRAMES  = 3,
  parameter int          FRAME_HOLD  = 4,
  parameter logic [7:0]  TRANSPARENT = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [10:0] trig_x,
  input  logic [9:0]  trig_y,
  input  logic        frame_tick,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [11:0] rom_address,
  output logic        rom_clken,
  input  logic [7:0]  rom_readdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  frame_idx,
  output logic        pixel_valid,
  output logic [7:0]  pixel_color
);

`ifdef EXPLOSION_SCALE2X_EN
  localparam int WIN_SH = 1;
`else
  localparam int WIN_SH = 0;
`endif
  localparam int          XSH      = $clog2(SPRITE_W);
  localparam int          HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [11:0] WIN_W    = 12'(SPRITE_W << WIN_SH);
  localparam logic [11:0] WIN_H    = 12'(SPRITE_H << WIN_SH);
  localparam logic [11:0] FRAME_SZ = 12'(SPRITE_W * SPRITE_H);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e              state_q, state_d;
  logic [10:0]         pos_x_q, pos_x_d;
  logic [9:0]          pos_y_q, pos_y_d;
  logic [1:0]          frame_idx_q, frame_idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_w;
  logic                hit_d1_q;
  logic                pixel_valid_q;
  logic [7:0]          pixel_color_q;

  logic [11:0] hx, vy, px, py, off_x, off_y, tex_x, tex_y;
  logic        in_x, in_y, hit;
  logic        opaque;

  // Stage 0: window test and ROM address, 12-bit so x+width never wraps
  always_comb begin
    hx    = {1'b0, hcount};
    vy    = {2'b0, vcount};
    px    = {1'b0, pos_x_q};
    py    = {2'b0, pos_y_q};
    in_x  = (hx >= px) && (hx < px + WIN_W);
    in_y  = (vy >= py) && (vy < py + WIN_H);
    hit   = (state_q == PLAY) && in_x && in_y;
    off_x = hx - px;
    off_y = vy - py;
    tex_x = off_x >> WIN_SH;
    tex_y = off_y >> WIN_SH;
    rom_address = '0;
    if (hit) begin
      rom_address = 12'(frame_idx_q) * FRAME_SZ + (tex_y << XSH) + tex_x;
    end
    rom_clken = hit;
  end

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    frame_idx_d = frame_idx_q;
    hold_d      = hold_q;
    done_w      = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous frame_tick is deliberately dropped here.
        if (trigger) begin
          pos_x_d     = trig_x;
          pos_y_d     = trig_y;
          frame_idx_d = '0;
          hold_d      = '0;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
            hold_d = '0;
            if (frame_idx_q == 2'(NUM_FRAMES - 1)) begin
              frame_idx_d = '0;
              done_w      = 1'b1;
              state_d     = IDLE;
            end else begin
              frame_idx_d = frame_idx_q + 2'd1;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      frame_idx_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      frame_idx_q <= frame_idx_d;
      hold_q      <= hold_d;
    end
  end

  // Stages 1 and 2: align the hit with the ROM's one-cycle read, then drop transparent texels
  assign opaque = hit_d1_q && (rom_readdata != TRANSPARENT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_d1_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_color_q <= '0;
    end else begin
      hit_d1_q      <= hit;
      pixel_valid_q <= opaque;
      pixel_color_q <= opaque ? rom_readdata : 8'h00;
    end
  end

  // busy drops in the same cycle as the done pulse
  assign done        = done_w;
  assign busy        = (state_q == PLAY) && !done_w;
  assign frame_idx   = frame_idx_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_color = pixel_color_q;

endmodule

// File: tb/tb_explosion_renderer.sv
// Scoreboard bench for explosion_renderer: directed scans push expected pixels, a monitor checks them two clocks later.
// Build with EXPLOSION_SCALE2X_EN defined to exercise the 2x window variant.
module tb_explosion_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trigger;
  logic [10:0] trig_x;
  logic [9:0]  trig_y;
  logic        frame_tick;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [11:0] rom_address;
  logic        rom_clken;
  logic [7:0]  rom_readdata;
  logic        busy;
  logic        done;
  logic [1:0]  frame_idx;
  logic        pixel_valid;
  logic [7:0]  pixel_color;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] c;
  } exp_t;
  exp_t exp_q[$];

  logic issued = 1'b0;
  logic iss_d1 = 1'b0;
  logic iss_d2 = 1'b0;

  logic [7:0] rom_mem [0:4095];

`ifdef EXPLOSION_SCALE2X_EN
  localparam logic [11:0] ADDR_F1 = 12'd1058;
  localparam logic [11:0] ADDR_F2 = 12'd2082;
  localparam logic [10:0] T_X     = 11'd102;
`else
  localparam logic [11:0] ADDR_F1 = 12'd1125;
  localparam logic [11:0] ADDR_F2 = 12'd2149;
  localparam logic [10:0] T_X     = 11'd101;
`endif

  explosion_renderer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trigger      (trigger),
    .trig_x       (trig_x),
    .trig_y       (trig_y),
    .frame_tick   (frame_tick),
    .hcount       (hcount),
    .vcount       (vcount),
    .rom_address  (rom_address),
    .rom_clken    (rom_clken),
    .rom_readdata (rom_readdata),
    .busy         (busy),
    .done         (done),
    .frame_idx    (frame_idx),
    .pixel_valid  (pixel_valid),
    .pixel_color  (pixel_color)
  );

  always #5 clk = ~clk;

  // Sprite ROM model with one-cycle registered read
  always @(posedge clk) begin
    if (rom_clken) rom_readdata <= rom_mem[rom_address];
  end

  always @(posedge clk) begin
    iss_d1 <= issued;
    iss_d2 <= iss_d1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one result per issued scan, exactly two clocks after issue
  always @(negedge clk) begin
    exp_t e;
    if (iss_d2) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel: got valid=%0b color=%02h with no expected entry", pixel_valid, pixel_color);
      end else begin
        e = exp_q.pop_front();
        $display("pixel t=%0t valid=%0b color=%02h (want %0b/%02h)", $time, pixel_valid, pixel_color, e.v, e.c);
        if (pixel_valid !== e.v || pixel_color !== e.c) begin
          errors++;
          $display("FAIL pixel: got valid=%0b color=%02h expected valid=%0b color=%02h",
                   pixel_valid, pixel_color, e.v, e.c);
        end
      end
    end else if (reset_n && pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_pixel: got valid=%0b expected 0", pixel_valid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [10:0] hx, input logic [9:0] vy, input logic exp_clk,
                      input logic [11:0] exp_addr, input logic exp_v, input logic [7:0] exp_c);
    exp_t e;
    hcount = hx;
    vcount = vy;
    issued = 1'b1;
    e.v = exp_v;
    e.c = exp_c;
    exp_q.push_back(e);
    #1;
    chk("rom_clken", 32'(rom_clken), 32'(exp_clk));
    chk("rom_address", 32'(rom_address), 32'(exp_addr));
    step();
    issued = 1'b0;
    hcount = '0;
    vcount = '0;
  endtask

  task automatic tick(input logic exp_done);
    frame_tick = 1'b1;
    #1;
    chk("done", 32'(done), 32'(exp_done));
    chk("busy_at_tick", 32'(busy), 32'(!exp_done));
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i) ^ 8'h5A;
    rom_mem[0]    = 8'h3C;
    rom_mem[1]    = 8'h00;
    rom_mem[2]    = 8'h00;
    rom_mem[1023] = 8'hE7;
    rom_mem[1024] = 8'h44;
    rom_mem[1058] = 8'h71;
    rom_mem[1125] = 8'h71;
    rom_mem[2082] = 8'h92;
    rom_mem[2149] = 8'h92;
    rom_readdata = 8'h00;

    reset_n = 1'b0; trigger = 1'b0; trig_x = '0; trig_y = '0;
    frame_tick = 1'b0; hcount = '0; vcount = '0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_frame_idx", 32'(frame_idx), 32'd0);
    chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("rst_pixel_color", 32'(pixel_color), 32'd0);
    chk("rst_rom_clken", 32'(rom_clken), 32'd0);
    reset_n = 1'b1;
    step();

    // No hit while idle
    scan(11'd100, 10'd50, 1'b0, 12'd0, 1'b0, 8'h00);

    trigger = 1'b1; trig_x = 11'd100; trig_y = 10'd50;
    step();
    trigger = 1'b0;
    chk("busy_after_trigger", 32'(busy), 32'd1);

    // Back-to-back scans in frame 0
    scan(11'd100, 10'd50, 1'b1, 12'd0, 1'b1, 8'h3C);
`ifdef EXPLOSION_SCALE2X_EN
    scan(11'd101, 10'd51, 1'b1, 12'd0, 1'b1, 8'h3C);
    scan(11'd163, 10'd113, 1'b1, 12'd1023, 1'b1, 8'hE7);
    scan(11'd164, 10'd50, 1'b0, 12'd0, 1'b0, 8'h00);
`else
    scan(11'd132, 10'd50, 1'b0, 12'd0, 1'b0, 8'h00);
    scan(11'd131, 10'd81, 1'b1, 12'd1023, 1'b1, 8'hE7);
    scan(11'd100, 10'd82, 1'b0, 12'd0, 1'b0, 8'h00);
`endif
    scan(11'd99, 10'd50, 1'b0, 12'd0, 1'b0, 8'h00);
    scan(T_X, 10'd50, 1'b1, 12'd1, 1'b0, 8'h00);

    // Trigger during PLAY must not move the sprite
    trigger = 1'b1; trig_x = 11'd200; trig_y = 10'd200;
    step();
    trigger = 1'b0;
    scan(11'd200, 10'd200, 1'b0, 12'd0, 1'b0, 8'h00);
    scan(11'd100, 10'd50, 1'b1, 12'd0, 1'b1, 8'h3C);

    for (int i = 0; i < 4; i++) tick(1'b0);
    chk("frame_idx_after_4", 32'(frame_idx), 32'd1);
    scan(11'd105, 10'd53, 1'b1, ADDR_F1, 1'b1, 8'h71);

    for (int i = 0; i < 4; i++) tick(1'b0);
    chk("frame_idx_after_8", 32'(frame_idx), 32'd2);
    scan(11'd105, 10'd53, 1'b1, ADDR_F2, 1'b1, 8'h92);

    for (int i = 0; i < 3; i++) tick(1'b0);
    // 12th tick with a simultaneous trigger that must be ignored
    trigger = 1'b1; trig_x = 11'd300; trig_y = 10'd300;
    tick(1'b1);
    trigger = 1'b0;
    chk("done_after_end", 32'(done), 32'd0);
    chk("busy_after_end", 32'(busy), 32'd0);
    chk("frame_idx_after_end", 32'(frame_idx), 32'd0);
    scan(11'd300, 10'd300, 1'b0, 12'd0, 1'b0, 8'h00);
    scan(11'd100, 10'd50, 1'b0, 12'd0, 1'b0, 8'h00);

    // Trigger plus tick in IDLE: trigger wins, tick dropped
    trigger = 1'b1; trig_x = 11'd10; trig_y = 10'd20; frame_tick = 1'b1;
    step();
    trigger = 1'b0; frame_tick = 1'b0;
    chk("busy_retrigger", 32'(busy), 32'd1);
    chk("frame_idx_retrigger", 32'(frame_idx), 32'd0);
    scan(11'd10, 10'd20, 1'b1, 12'd0, 1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) tick(1'b0);
    chk("hold_not_counted", 32'(frame_idx), 32'd0);
    tick(1'b0);
    chk("frame_idx_retrigger_4", 32'(frame_idx), 32'd1);
    repeat (3) step();

    // Asynchronous reset mid-animation
    hcount = 11'd10; vcount = 10'd20;
    #1;
    chk("pre_reset_clken", 32'(rom_clken), 32'd1);
    chk("pre_reset_addr", 32'(rom_address), 32'd1024);
    reset_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_idx", 32'(frame_idx), 32'd0);
    chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("reset_rom_clken", 32'(rom_clken), 32'd0);
    step();
    hcount = '0; vcount = '0;
    reset_n = 1'b1;
    repeat (4) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
